// File: rtl/easy_driver_array.sv
// easy_driver_array: Avalon-MM programmed step/dir pulse generator for EasyDriver boards.
// Each channel runs an independent IDLE/SETUP/HIGH/LOW move sequencer.
module easy_driver_array #(
    parameter  int CHANNELS  = 2,
    parameter  int STEP_W    = 24,
    parameter  int PULSE_W   = 4,
    parameter  int DIR_SETUP = 8,
    localparam int AW        = $clog2(CHANNELS) + 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [AW-1:0]       avs_address,
    input  logic                avs_write,
    input  logic                avs_read,
    input  logic [31:0]         avs_writedata,
    output logic [31:0]         avs_readdata,
    output logic                irq,
    output logic [CHANNELS-1:0] step_out,
    output logic [CHANNELS-1:0] dir_out,
    output logic [CHANNELS-1:0] enable_n_out
);

    // Bus handshake: no waitrequest. A write is accepted on every clock its strobe is
    // high; a read strobe sampled at one edge returns its data on avs_readdata after it.
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW} state_t;

    localparam logic [31:0] MIN_PERIOD = 32'(2 * PULSE_W);

    logic [AW-1:0]       ch_sel;
    logic [1:0]          reg_sel;
    logic [31:0]         rd_word [CHANNELS];
    logic [31:0]         rd_any;
    logic [CHANNELS-1:0] irq_vec;
    logic                unused_bits;

    assign ch_sel      = avs_address >> 2;
    assign reg_sel     = avs_address[1:0];
    assign unused_bits = ^avs_writedata[31:5];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t            state, state_nx;
        logic              ctrl_en, ctrl_dir, ctrl_irq_en;
        logic              dir_lat, done, aborted;
        logic [STEP_W-1:0] target, period, remaining;
        logic [31:0]       cnt, eff_period, low_len, low_len_lat;
        logic [31:0]       rd_w;
        logic              sel, wr_ctrl, wr_steps, wr_period, wr_status;
        logic              start_req, abort_req, go, zero_start, kill;
        logic              busy, cnt_zero, step_done, move_done;
        logic              step_o, dir_o;

        assign sel       = (ch_sel == AW'(i));
        assign wr_ctrl   = avs_write && sel && (reg_sel == 2'd0);
        assign wr_steps  = avs_write && sel && (reg_sel == 2'd1);
        assign wr_period = avs_write && sel && (reg_sel == 2'd2);
        assign wr_status = avs_write && sel && (reg_sel == 2'd3);

        assign busy      = (state != S_IDLE);
        assign cnt_zero  = (cnt == 32'd0);
        assign start_req = wr_ctrl && avs_writedata[2];
        assign abort_req = wr_ctrl && (avs_writedata[3] || !avs_writedata[0]);

        // Start only counts with enable set in the same write; abort bit beats start.
        assign go         = !busy && start_req && avs_writedata[0] && !avs_writedata[3]
                            && (target != '0);
        assign zero_start = !busy && start_req && avs_writedata[0] && !avs_writedata[3]
                            && (target == '0);
        assign kill       = busy ? abort_req : (start_req && avs_writedata[3]);
        assign step_done  = (state == S_HIGH) && cnt_zero && !kill;
        assign move_done  = (state == S_LOW) && cnt_zero && (remaining == '0) && !kill;

        assign eff_period = (32'(period) < MIN_PERIOD) ? MIN_PERIOD : 32'(period);
        assign low_len    = eff_period - 32'(PULSE_W);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) state <= S_IDLE;
            else       state <= state_nx;
        end

        always_comb begin
            state_nx = state;
            if (busy && kill) begin
                state_nx = S_IDLE;
            end else begin
                case (state)
                    S_IDLE:  if (go) state_nx = S_SETUP;
                    S_SETUP: if (cnt_zero) state_nx = S_HIGH;
                    S_HIGH:  if (cnt_zero) state_nx = S_LOW;
                    S_LOW:   if (cnt_zero) state_nx = (remaining == '0) ? S_IDLE : S_HIGH;
                    default: state_nx = S_IDLE;
                endcase
            end
        end

        always_comb begin
            step_o = 1'b0;
            dir_o  = ctrl_dir;
            if (state == S_HIGH) step_o = 1'b1;
            if (busy) dir_o = dir_lat;
        end

        // Every state change reloads the phase counter with that phase's length minus one.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt <= 32'd0;
            end else if (state_nx != state) begin
                case (state_nx)
                    S_SETUP: cnt <= 32'(DIR_SETUP - 1);
                    S_HIGH:  cnt <= 32'(PULSE_W - 1);
                    S_LOW:   cnt <= low_len_lat - 32'd1;
                    default: cnt <= 32'd0;
                endcase
            end else if (!cnt_zero) begin
                cnt <= cnt - 32'd1;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                ctrl_en     <= 1'b0;
                ctrl_dir    <= 1'b0;
                ctrl_irq_en <= 1'b0;
                dir_lat     <= 1'b0;
                target      <= '0;
                period      <= '0;
                remaining   <= '0;
                low_len_lat <= 32'd0;
                done        <= 1'b0;
                aborted     <= 1'b0;
            end else begin
                if (wr_ctrl) begin
                    ctrl_en     <= avs_writedata[0];
                    ctrl_dir    <= avs_writedata[1];
                    ctrl_irq_en <= avs_writedata[4];
                end
                if (wr_period) period <= STEP_W'(avs_writedata);
                if (wr_steps) begin
                    target <= STEP_W'(avs_writedata);
                    if (!busy) remaining <= STEP_W'(avs_writedata);
                end
                if (go) begin
                    dir_lat     <= avs_writedata[1];
                    remaining   <= target;
                    low_len_lat <= low_len;
                end else if (step_done) begin
                    remaining <= remaining - STEP_W'(1);
                end
                // Hardware set of a sticky flag wins over a W1C in the same clock.
                if (go) begin
                    done    <= 1'b0;
                    aborted <= 1'b0;
                end else begin
                    if (move_done || zero_start)         done <= 1'b1;
                    else if (wr_status && avs_writedata[1]) done <= 1'b0;
                    if (kill)                            aborted <= 1'b1;
                    else if (wr_status && avs_writedata[2]) aborted <= 1'b0;
                end
            end
        end

        always_comb begin
            rd_w = 32'd0;
            case (reg_sel)
                2'd0: rd_w = {27'd0, ctrl_irq_en, 2'b00, ctrl_dir, ctrl_en};
                2'd1: rd_w = 32'(remaining);
                2'd2: rd_w = 32'(period);
                2'd3: rd_w = {29'd0, aborted, done, busy};
                default: rd_w = 32'd0;
            endcase
        end

        assign rd_word[i]      = sel ? rd_w : 32'd0;
        assign irq_vec[i]      = done & ctrl_irq_en;
        assign step_out[i]     = step_o;
        assign dir_out[i]      = dir_o;
        assign enable_n_out[i] = ~ctrl_en;
    end

    always_comb begin
        rd_any = 32'd0;
        for (int k = 0; k < CHANNELS; k++) rd_any = rd_any | rd_word[k];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avs_readdata <= 32'd0;
            irq          <= 1'b0;
        end else begin
            irq <= |irq_vec;
            if (avs_read) avs_readdata <= rd_any;
        end
    end

endmodule

// File: tb/tb_easy_driver_array.sv
// Bench for easy_driver_array: randomized and directed moves; expected STEP rise cycles
// and read data come from a spec-level timing model and are popped by a negedge monitor.
module tb_easy_driver_array;

    localparam int CHANNELS  = 2;
    localparam int STEP_W    = 24;
    localparam int PULSE_W   = 4;
    localparam int DIR_SETUP = 8;
    localparam int AW        = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic [AW-1:0]       avs_address;
    logic                avs_write, avs_read;
    logic [31:0]         avs_writedata, avs_readdata;
    logic                irq;
    logic [CHANNELS-1:0] step_out, dir_out, enable_n_out;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] exp_q[$];
    int          rise_q0[$];
    int          rise_q1[$];
    bit          rd_pend = 1'b0;
    bit          prev_step[2];
    int          hi_len[2];

    easy_driver_array #(
        .CHANNELS(CHANNELS), .STEP_W(STEP_W), .PULSE_W(PULSE_W), .DIR_SETUP(DIR_SETUP)
    ) dut (
        .clk(clk), .reset(reset), .avs_address(avs_address), .avs_write(avs_write),
        .avs_read(avs_read), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .irq(irq), .step_out(step_out), .dir_out(dir_out), .enable_n_out(enable_n_out)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_pend <= avs_read && !reset;
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got an event, expected none (cycle %0d)", name, cyc);
    endtask

    function automatic void push_rise(input int ch, input int c);
        if (ch == 0) rise_q0.push_back(c);
        else         rise_q1.push_back(c);
    endfunction

    function automatic int rise_count(input int ch);
        return (ch == 0) ? rise_q0.size() : rise_q1.size();
    endfunction

    function automatic int pop_rise(input int ch);
        if (ch == 0) return rise_q0.pop_front();
        return rise_q1.pop_front();
    endfunction

    // Drops expected rises at or after 'from' (the move was stopped before them).
    function automatic void cancel_rises(input int ch, input int from);
        int keep[$];
        if (ch == 0) begin
            foreach (rise_q0[k]) if (rise_q0[k] < from) keep.push_back(rise_q0[k]);
            rise_q0 = keep;
        end else begin
            foreach (rise_q1[k]) if (rise_q1[k] < from) keep.push_back(rise_q1[k]);
            rise_q1 = keep;
        end
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            prev_step[0] = 1'b0;
            prev_step[1] = 1'b0;
            hi_len[0]    = 0;
            hi_len[1]    = 0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (step_out[ch] && !prev_step[ch]) begin
                    hi_len[ch] = 1;
                    if (rise_count(ch) == 0) flag_fail($sformatf("unexpected_rise_ch%0d", ch));
                    else check($sformatf("rise_cycle_ch%0d", ch), cyc, pop_rise(ch));
                end else if (step_out[ch]) begin
                    hi_len[ch]++;
                end else if (prev_step[ch]) begin
                    check($sformatf("pulse_width_ch%0d", ch), hi_len[ch], PULSE_W);
                end
                prev_step[ch] = step_out[ch];
            end
            if (rd_pend) begin
                if (exp_q.size() == 0) flag_fail("unexpected_read");
                else check("readdata", avs_readdata, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [AW-1:0] addr(input int ch, input int r);
        return AW'((ch << 2) | r);
    endfunction

    task automatic bus_write(input int ch, input int r, input logic [31:0] d);
        avs_address   = addr(ch, r);
        avs_writedata = d;
        avs_write     = 1'b1;
        @(posedge clk); #1;
        avs_write     = 1'b0;
    endtask

    task automatic bus_read(input int ch, input int r, input logic [31:0] e);
        exp_q.push_back(e);
        avs_address = addr(ch, r);
        avs_read    = 1'b1;
        @(posedge clk); #1;
        avs_read    = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic program_ch(input int ch, input int steps, input int period);
        bus_write(ch, 1, 32'(steps));
        bus_write(ch, 2, 32'(period));
    endtask

    // Issues enable+start and records the model's rise cycles and completion cycle.
    task automatic go(input int ch, input int steps, input int period, input bit dir,
                      input bit irq_en, output int t_start, output int t_done);
        int eff;
        t_start = cyc;
        eff = (period < 2 * PULSE_W) ? 2 * PULSE_W : period;
        for (int k = 0; k < steps; k++) push_rise(ch, t_start + 1 + DIR_SETUP + k * eff);
        t_done = (steps == 0) ? t_start + 1 : t_start + 1 + DIR_SETUP + steps * eff;
        bus_write(ch, 0, 32'({irq_en, 1'b0, 1'b1, dir, 1'b1}));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t, td, t1, td1;
        int rch, rst_steps, rpd;
        bit rdir;
        reset = 1'b1;
        avs_write = 1'b0;
        avs_read = 1'b0;
        avs_address = '0;
        avs_writedata = 32'd0;
        #1;
        check("rst_step", step_out, 0);
        check("rst_dir", dir_out, 0);
        check("rst_enable_n", enable_n_out, 2'b11);
        check("rst_irq", irq, 0);
        check("rst_readdata", avs_readdata, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 2; c++) for (int r = 0; r < 4; r++) bus_read(c, r, 32'd0);

        // Three pulses, PERIOD 20, dir=1, irq enabled.
        program_ch(0, 3, 20);
        go(0, 3, 20, 1'b1, 1'b1, t, td);
        check("enable_n_after_write", enable_n_out, 2'b10);
        check("dir_during_move", dir_out[0], 1);
        wait_cyc(td - 1);
        bus_read(0, 3, 32'h1);
        check("irq_at_done", irq, 0);
        bus_read(0, 3, 32'h2);
        check("irq_after_done", irq, 1);
        bus_read(0, 1, 32'd0);
        bus_read(0, 0, 32'h13);
        bus_write(0, 3, 32'h2);
        @(posedge clk); #1;
        check("irq_cleared", irq, 0);

        // PERIOD below 2*PULSE_W, and a done W1C colliding with the hardware set.
        program_ch(0, 2, 3);
        go(0, 2, 3, 1'b0, 1'b0, t, td);
        wait_cyc(td - 1);
        bus_write(0, 3, 32'h2);
        bus_read(0, 3, 32'h2);

        // STEPS=0 start: no pulse, done next clock, never busy.
        bus_write(0, 3, 32'h6);
        bus_write(0, 1, 32'd0);
        go(0, 0, 5, 1'b0, 1'b0, t, td);
        bus_read(0, 3, 32'h2);

        // Abort in LOW after the second pulse.
        program_ch(0, 100, 10);
        go(0, 100, 10, 1'b0, 1'b0, t, td);
        wait_cyc(t + 24);
        bus_write(0, 0, 32'h9);
        cancel_rises(0, t + 25);
        check("step_after_abort", step_out[0], 0);
        bus_read(0, 3, 32'h4);
        bus_read(0, 1, 32'd98);
        bus_read(0, 0, 32'h1);

        // Two channels with different periods; ch1 dir write mid-move.
        program_ch(0, 3, 10);
        program_ch(1, 3, 16);
        go(0, 3, 10, 1'b0, 1'b0, t, td);
        go(1, 3, 16, 1'b1, 1'b0, t1, td1);
        wait_cyc(t1 + 20);
        bus_write(1, 0, 32'h1);
        check("dir1_held_mid_move", dir_out[1], 1);
        wait_cyc(td1 + 1);
        check("dir1_idle_follows_ctrl", dir_out[1], 0);
        check("dir0_idle", dir_out[0], 0);
        bus_read(0, 3, 32'h2);
        bus_read(1, 3, 32'h2);

        // Randomized single-channel moves.
        for (int n = 0; n < 6; n++) begin
            rch       = $urandom_range(0, 1);
            rst_steps = $urandom_range(1, 5);
            rpd       = $urandom_range(1, 24);
            rdir      = 1'($urandom_range(0, 1));
            program_ch(rch, rst_steps, rpd);
            go(rch, rst_steps, rpd, rdir, 1'b0, t, td);
            check("dir_rand", dir_out[rch], 32'(rdir));
            wait_cyc(td - 1);
            bus_read(rch, 3, 32'h1);
            bus_read(rch, 3, 32'h2);
            bus_read(rch, 1, 32'd0);
        end

        // Reset during a HIGH phase.
        program_ch(0, 5, 10);
        go(0, 5, 10, 1'b1, 1'b1, t, td);
        wait_cyc(t + 10);
        check("step_high_before_reset", step_out[0], 1);
        reset = 1'b1;
        #1;
        cancel_rises(0, cyc);
        check("reset_step", step_out, 0);
        check("reset_enable_n", enable_n_out, 2'b11);
        check("reset_dir", dir_out, 0);
        check("reset_irq", irq, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 2; c++) for (int r = 0; r < 4; r++) bus_read(c, r, 32'd0);
        repeat (80) @(posedge clk);
        #1;
        check("rises_outstanding", rise_q0.size() + rise_q1.size(), 0);
        check("reads_outstanding", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected to finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
